instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, output buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid&in_ready.
REQ-006 SHALL have port in_opcode  input  5  major opcode (instruction bits 6:2).
REQ-007 SHALL have ports in_rd, in_rs1, in_rs2, in_rs3  input  5 each  register fields.
REQ-008 SHALL have ports in_funct3 input 3, in_funct7 input 7  function fields (funct7[1:0] is fmt for R4).
REQ-009 SHALL have port in_imm  input  32  signed byte-offset/immediate value.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, out_instr output 32  encoded word.
REQ-011 SHALL have ports err_pulse output 1 (one-cycle reject), err_count output 8 (saturating rejects).

Function
REQ-012 Format map SHALL be: 00000 I, 01000 S, 10000 R4, 11000 B, 11001 I, 11011 J, 00100 I, 01100 R, 00101 U, 01101 U, 00110 I, 01110 R; all other opcodes unsupported.
REQ-013 out_instr[1:0] SHALL be 2'b11 and out_instr[6:2] SHALL equal in_opcode for every emitted word.
REQ-014 Field placement SHALL follow RV32 base formats R/I/S/B/U/J/R4 exactly; rs3 at [31:27] for R4.
REQ-015 U format SHALL place in_imm[31:12] at [31:12]; B/J SHALL scatter imm bits per ISA, dropping imm[0].
REQ-016 in_ready SHALL equal (fifo count < FIFO_DEPTH); no combinational path from out_ready to in_ready.
REQ-017 Accepted request SHALL be encoded and written into FIFO on the same edge; out_valid rises the next cycle (latency 1 when empty).
REQ-018 out_valid SHALL equal (count != 0); out_instr SHALL show head entry and SHALL hold stable while out_valid&!out_ready.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and preserve order; pointers wrap modulo FIFO_DEPTH.
REQ-020 Unsupported opcode on an accepted request SHALL NOT be enqueued; err_pulse=1 the following cycle only.
REQ-021 err_count SHALL increment by 1 per reject and saturate at 255.
REQ-022 Output order SHALL equal acceptance order of non-rejected requests.

Reset
REQ-023 When rst_n=0 at a clock edge: count=0, pointers=0, out_valid=0, err_pulse=0, err_count=0; in_ready=1 the cycle after reset deasserts.
REQ-024 Reset mid-stream SHALL discard all buffered words; no word accepted before reset emerges after it.
REQ-025 in_valid during reset SHALL be ignored.

Configuration
REQ-026 Macro INSTR_ENC_RANGE_CHECK_EN defined: I/S imm outside [-2048,2047], B outside [-4096,4094] or odd, J outside [-2^20,2^20-2] or odd, U with imm[11:0]!=0 SHALL be rejected per REQ-020/021.
REQ-027 Macro undefined: immediates SHALL be silently truncated per REQ-015; only unsupported opcodes are rejected.

Verification
REQ-028 Reset, then opcode 00100, rd=1, rs1=0, funct3=0, imm=5 -> next cycle out_instr=32'h00500093, out_valid=1.
REQ-029 Opcode 11011, rd=1, imm=-4 -> out_instr=32'hFFDFF0EF.
REQ-030 out_ready=0, push 3 words (FIFO_DEPTH=2) -> in_ready=0 after 2 accepted, third held; release out_ready -> 3 words in order.
REQ-031 Opcode 00111 -> nothing enqueued, err_pulse one cycle, err_count=1; 300 rejects -> err_count=255.
REQ-032 With INSTR_ENC_RANGE_CHECK_EN: opcode 00100 imm=4096 -> reject; without: emitted as 32'h00000013 with rd=0, rs1=0.
REQ-033 Two words buffered, rst_n=0 one edge -> out_valid=0 next cycle, neither word ever emitted.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: decoded request fields are packed into a 32-bit word and buffered in a small FIFO.
// Optional macro INSTR_ENC_RANGE_CHECK_EN rejects immediates that do not fit their encoding.
module instr_encoder #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rs3,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R4   = 3'd6,
    FMT_NONE = 3'd7
  } fmt_e;

  function automatic fmt_e decode_fmt(input logic [4:0] op);
    case (op)
      5'b00000: decode_fmt = FMT_I;
      5'b01000: decode_fmt = FMT_S;
      5'b10000: decode_fmt = FMT_R4;
      5'b11000: decode_fmt = FMT_B;
      5'b11001: decode_fmt = FMT_I;
      5'b11011: decode_fmt = FMT_J;
      5'b00100: decode_fmt = FMT_I;
      5'b01100: decode_fmt = FMT_R;
      5'b00101: decode_fmt = FMT_U;
      5'b01101: decode_fmt = FMT_U;
      5'b00110: decode_fmt = FMT_I;
      5'b01110: decode_fmt = FMT_R;
      default:  decode_fmt = FMT_NONE;
    endcase
  endfunction

  function automatic logic [31:0] encode(
    input fmt_e        fmt,
    input logic [4:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rs3,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [6:0] opc;
    opc = {op, 2'b11};
    case (fmt)
      FMT_R:   encode = {f7, rs2, rs1, f3, rd, opc};
      FMT_I:   encode = {imm[11:0], rs1, f3, rd, opc};
      FMT_S:   encode = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      FMT_B:   encode = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      FMT_U:   encode = {imm[31:12], rd, opc};
      FMT_J:   encode = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      FMT_R4:  encode = {rs3, f7[1:0], rs2, rs1, f3, rd, opc};
      default: encode = 32'h0000_0000;
    endcase
  endfunction

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // Sign-extension checks: the bits above the encodable range must all equal the sign bit.
  function automatic logic imm_ok(input fmt_e fmt, input logic [31:0] imm);
    case (fmt)
      FMT_I, FMT_S: imm_ok = (imm[31:11] == {21{imm[31]}});
      FMT_B:        imm_ok = (imm[31:12] == {20{imm[31]}}) && (imm[0] == 1'b0);
      FMT_J:        imm_ok = (imm[31:20] == {12{imm[31]}}) && (imm[0] == 1'b0);
      FMT_U:        imm_ok = (imm[11:0] == 12'h000);
      default:      imm_ok = 1'b1;
    endcase
  endfunction
`endif

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err_pulse;
  logic [7:0]    r_err_count;

  fmt_e        w_fmt;
  logic [31:0] w_word;
  logic        w_range_ok;
  logic        w_accept;
  logic        w_reject;
  logic        w_push;
  logic        w_pop;

  // Request decode, encoding and accept/reject classification.
  always_comb begin
    w_fmt  = decode_fmt(in_opcode);
    w_word = encode(w_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_rs3, in_funct3, in_funct7, in_imm);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    w_range_ok = imm_ok(w_fmt, in_imm);
`else
    w_range_ok = 1'b1;
`endif
    w_accept = in_valid & in_ready;
    if (w_accept) begin
      w_reject = (w_fmt == FMT_NONE) | ~w_range_ok;
    end else begin
      w_reject = 1'b0;
    end
    w_push = w_accept & ~w_reject;
    w_pop  = out_valid & out_ready;
  end

  // FIFO storage, pointers, occupancy and reject bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_err_pulse <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      r_err_pulse <= w_reject;
      if (w_reject && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'h01;
      end
    end
  end

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (r_count < DEPTH_C);
  assign out_valid = (r_count != {CW{1'b0}});
  assign out_instr = r_mem[r_rd_ptr];
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder plus backpressure, saturation and reset sequences.
module tb_instr_encoder;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rs3;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err_pulse;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_errs = 0;

  instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rs3, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] exp,
                              input logic err);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp = exp; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_rs3 = v.rs3;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  function automatic logic [31:0] addi_word(input int k);
    logic [11:0] imm12;
    imm12 = 12'(k);
    return {imm12, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  // Push n ADDI x1,x0,base+k words, holding out_ready low for 'stall' cycles; checks output order.
  task automatic stream(input int n, input int base, input int stall);
    int   sent;
    int   got;
    int   cyc;
    logic acc;
    sent = 0; got = 0; cyc = 0;
    while ((got < n) && (cyc < 200)) begin
      @(negedge clk);
      out_ready = (cyc >= stall);
      if (sent < n) begin
        drive(mk(5'b00100, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'(base + sent), 32'h0, 1'b0));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if ((cyc < stall) && (sent >= DEPTH)) begin
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_head_stable", out_instr, addi_word(base));
      end
      acc = in_valid & in_ready;
      if (out_valid && out_ready) begin
        check("stream_order", out_instr, addi_word(base + got));
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("stream_complete", 32'(got), 32'(n));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(5'b00100, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0, 1'b0));

    vecs[0]  = mk(5'b00100, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,         32'h00500093, 1'b0);
    vecs[1]  = mk(5'b11011, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, -32'sd4,       32'hFFDFF0EF, 1'b0);
    vecs[2]  = mk(5'b01100, 5'd3, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'd0,         32'h002081B3, 1'b0);
    vecs[3]  = mk(5'b01100, 5'd3, 5'd1, 5'd2, 5'd0, 3'd0, 7'h20, 32'd0,         32'h402081B3, 1'b0);
    vecs[4]  = mk(5'b01000, 5'd0, 5'd1, 5'd2, 5'd0, 3'd2, 7'h00, 32'd8,         32'h0020A423, 1'b0);
    vecs[5]  = mk(5'b11000, 5'd0, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, -32'sd8,       32'hFE208CE3, 1'b0);
    vecs[6]  = mk(5'b01101, 5'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000,  32'h123452B7, 1'b0);
    vecs[7]  = mk(5'b10000, 5'd1, 5'd2, 5'd3, 5'd4, 3'd0, 7'h00, 32'd0,         32'h203100C3, 1'b0);
    vecs[8]  = mk(5'b10000, 5'd1, 5'd2, 5'd3, 5'd4, 3'd0, 7'h01, 32'd0,         32'h223100C3, 1'b0);
    vecs[9]  = mk(5'b11001, 5'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,         32'h00008067, 1'b0);
    vecs[10] = mk(5'b00000, 5'd2, 5'd1, 5'd0, 5'd0, 3'd2, 7'h00, 32'd4,         32'h0040A103, 1'b0);
    vecs[11] = mk(5'b01110, 5'd1, 5'd2, 5'd3, 5'd0, 3'd0, 7'h00, 32'd0,         32'h003100BB, 1'b0);
    vecs[12] = mk(5'b00110, 5'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, -32'sd1,       32'hFFF1009B, 1'b0);
    vecs[13] = mk(5'b00111, 5'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,         32'h00000000, 1'b1);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    vecs[14] = mk(5'b00100, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,      32'h00000000, 1'b1);
    vecs[15] = mk(5'b00101, 5'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345ABC,  32'h00000000, 1'b1);
`else
    vecs[14] = mk(5'b00100, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,      32'h00000013, 1'b0);
    vecs[15] = mk(5'b00101, 5'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345ABC,  32'h12345297, 1'b0);
`endif

    // Reset with in_valid asserted: nothing may be captured.
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      in_valid = 1'b1;
      check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      if (vecs[i].err) begin
        exp_errs++;
        check($sformatf("v%0d_err_pulse", i), {31'd0, err_pulse}, 32'd1);
        check($sformatf("v%0d_no_out", i), {31'd0, out_valid}, 32'd0);
      end else begin
        check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
        check($sformatf("v%0d_out_instr", i), out_instr, vecs[i].exp);
        check($sformatf("v%0d_no_err", i), {31'd0, err_pulse}, 32'd0);
      end
      check($sformatf("v%0d_err_count", i), {24'd0, err_count}, 32'(exp_errs));
      @(negedge clk);
      check($sformatf("v%0d_drained", i), {31'd0, out_valid}, 32'd0);
      check($sformatf("v%0d_pulse_low", i), {31'd0, err_pulse}, 32'd0);
    end

    // Backpressure: three words with out_ready low, then released.
    stream(3, 10, 4);
    // Continuous simultaneous push/pop.
    out_ready = 1'b1;
    stream(5, 40, 0);

    // 300 back-to-back rejects saturate err_count.
    @(negedge clk);
    drive(mk(5'b00111, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 32'h0, 1'b0));
    in_valid = 1'b1;
    repeat (300) @(negedge clk);
    check("sat_err_pulse", {31'd0, err_pulse}, 32'd1);
    check("sat_in_ready", {31'd0, in_ready}, 32'd1);
    check("sat_no_out", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("sat_err_count", {24'd0, err_count}, 32'd255);
    check("sat_pulse_end", {31'd0, err_pulse}, 32'd0);

    // Reset with two words buffered: both must be discarded.
    out_ready = 1'b0;
    drive(mk(5'b00100, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100, 32'h0, 1'b0));
    in_valid = 1'b1;
    @(negedge clk);
    in_imm = 32'd101;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    check("pre_rst_head", out_instr, addi_word(100));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("mid_rst_quiet%0d", c), {31'd0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
